nf10_tx_port_gate: RTL and testbench

//  Egress-side AXI4-Stream gate in front of a 10G interface's s_axis slave port.

---
 rtl/nf10_axis_pkg.sv | 23 ++
 rtl/nf10_strb_popcount.sv | 17 +
 rtl/nf10_tx_port_gate.sv | 148 ++++++++++++++
 tb/tb_nf10_tx_port_gate.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_axis_pkg.sv
// Shared NetFPGA AXI4-Stream definitions: tuser field offsets, one-hot port codes, gate FSM states.
package nf10_axis_pkg;

    localparam int unsigned TUSER_LEN_LO = 0;
    localparam int unsigned TUSER_SRC_LO = 16;
    localparam int unsigned TUSER_DST_LO = 24;

    localparam logic [7:0] MAC0 = 8'h01;
    localparam logic [7:0] CPU0 = 8'h02;
    localparam logic [7:0] MAC1 = 8'h04;
    localparam logic [7:0] CPU1 = 8'h08;
    localparam logic [7:0] MAC2 = 8'h10;
    localparam logic [7:0] CPU2 = 8'h20;
    localparam logic [7:0] MAC3 = 8'h40;
    localparam logic [7:0] CPU3 = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DROP
    } gate_state_t;

endpackage

// File: rtl/nf10_strb_popcount.sv
// Combinational tstrb -> valid byte count; shared with the ingress-side length insertion.
module nf10_strb_popcount #(
    parameter int unsigned STRB_WIDTH = 8,
    localparam int unsigned CNT_W     = $clog2(STRB_WIDTH + 1)
) (
    input  logic [STRB_WIDTH-1:0] strb,
    output logic [CNT_W-1:0]      byte_cnt
);

    always_comb begin
        byte_cnt = '0;
        for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
            byte_cnt = byte_cnt + {{(CNT_W-1){1'b0}}, strb[i]};
        end
    end

endmodule

// File: rtl/nf10_tx_port_gate.sv
// Egress port gate: forwards packets whose tuser dst_port hits C_PORT_MASK, drops the rest, flags length errors.
// Optional packet/error counters enabled by defining NF10_TX_PORT_GATE_STATS_EN.
module nf10_tx_port_gate
    import nf10_axis_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 64,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0]  C_PORT_MASK        = 8'h10
) (
    input  logic                            axi_aclk,
    input  logic                            axi_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            len_err
`ifdef NF10_TX_PORT_GATE_STATS_EN
    ,
    output logic [31:0]                     fwd_pkt_cnt,
    output logic [31:0]                     drop_pkt_cnt,
    output logic [31:0]                     len_err_cnt
`endif
);

    localparam int unsigned STRB_W = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(STRB_W + 1);

    gate_state_t       state, state_next;
    logic [15:0]       byte_cnt;
    logic [15:0]       cnt_next;
    logic [16:0]       cnt_sum;
    logic [15:0]       base_cnt;
    logic [15:0]       exp_len;
    logic [CNT_W-1:0]  beat_bytes;
    logic              accept;
    logic              dst_hit;
    logic              fwd_load;
    logic              drop_beat;
    logic              len_mismatch;

    nf10_strb_popcount #(
        .STRB_WIDTH (STRB_W)
    ) u_strb_popcount (
        .strb     (s_axis_tstrb),
        .byte_cnt (beat_bytes)
    );

    assign s_axis_tready = (state == DROP) | ~m_axis_tvalid | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign dst_hit       = |(s_axis_tuser[TUSER_DST_LO +: 8] & C_PORT_MASK);

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fwd_load   = 1'b0;
        drop_beat  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (dst_hit) begin
                        fwd_load   = 1'b1;
                        state_next = s_axis_tlast ? IDLE : FWD;
                    end else begin
                        drop_beat  = 1'b1;
                        state_next = s_axis_tlast ? IDLE : DROP;
                    end
                end
            end
            FWD: begin
                if (accept) begin
                    fwd_load = 1'b1;
                    if (s_axis_tlast) state_next = IDLE;
                end
            end
            DROP: begin
                if (accept) begin
                    drop_beat = 1'b1;
                    if (s_axis_tlast) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // First beat compares against its own tuser; later beats against the copy latched on m_axis_tuser.
    always_comb begin
        base_cnt     = (state == IDLE) ? '0 : byte_cnt;
        cnt_sum      = {1'b0, base_cnt} + {{(17-CNT_W){1'b0}}, beat_bytes};
        cnt_next     = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        exp_len      = (state == IDLE) ? s_axis_tuser[TUSER_LEN_LO +: 16]
                                       : m_axis_tuser[TUSER_LEN_LO +: 16];
        len_mismatch = fwd_load & s_axis_tlast & (cnt_next != exp_len);
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            byte_cnt      <= '0;
            len_err       <= 1'b0;
        end else begin
            len_err <= len_mismatch;
            if (fwd_load) begin
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tstrb  <= s_axis_tstrb;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tvalid <= 1'b1;
                byte_cnt      <= cnt_next;
                if (state == IDLE) m_axis_tuser <= s_axis_tuser;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef NF10_TX_PORT_GATE_STATS_EN
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            fwd_pkt_cnt  <= '0;
            drop_pkt_cnt <= '0;
            len_err_cnt  <= '0;
        end else begin
            if (fwd_load & s_axis_tlast)  fwd_pkt_cnt  <= fwd_pkt_cnt + 32'd1;
            if (drop_beat & s_axis_tlast) drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
            if (len_mismatch)             len_err_cnt  <= len_err_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nf10_tx_port_gate.sv
// Scoreboard bench for nf10_tx_port_gate (C_PORT_MASK = 8'h10); counter checks follow NF10_TX_PORT_GATE_STATS_EN.
module tb_nf10_tx_port_gate;
    import nf10_axis_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  s_tdata;
    logic [7:0]   s_tstrb;
    logic [127:0] s_tuser;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [63:0]  m_tdata;
    logic [7:0]   m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic         len_err;
`ifdef NF10_TX_PORT_GATE_STATS_EN
    logic [31:0]  fwd_pkt_cnt, drop_pkt_cnt, len_err_cnt;
`endif

    always #5 clk = ~clk;

    nf10_tx_port_gate #(
        .C_AXIS_DATA_WIDTH  (64),
        .C_AXIS_TUSER_WIDTH (128),
        .C_PORT_MASK        (8'h10)
    ) dut (
        .axi_aclk      (clk),
        .axi_resetn    (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .len_err       (len_err)
`ifdef NF10_TX_PORT_GATE_STATS_EN
        ,
        .fwd_pkt_cnt   (fwd_pkt_cnt),
        .drop_pkt_cnt  (drop_pkt_cnt),
        .len_err_cnt   (len_err_cnt)
`endif
    );

    typedef struct packed {
        logic [63:0]  d;
        logic [7:0]   s;
        logic [127:0] u;
        logic         l;
        logic         e;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_fwd = 0, exp_drop = 0, exp_lerr = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks hold-stability under stall.
    logic         lerr_seen = 1'b0;
    logic         stall_prev = 1'b0;
    logic [201:0] snap;
    beat_t        got_b, exp_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            lerr_seen  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_stable", {54'd0, m_tdata, m_tstrb, m_tuser, m_tlast, m_tvalid}, {54'd0, snap});
            if (m_tvalid && len_err) lerr_seen = 1'b1;
            if (!m_tvalid && len_err) check("len_err_without_valid", 256'd1, 256'd0);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {192'd0, m_tdata}, 256'd0);
                end else begin
                    exp_b = exp_q.pop_front();
                    got_b = '{d: m_tdata, s: m_tstrb, u: m_tuser, l: m_tlast, e: lerr_seen};
                    check("out_beat", {54'd0, got_b}, {54'd0, exp_b});
                end
                lerr_seen = 1'b0;
            end
            stall_prev = m_tvalid && !m_tready;
            snap       = {m_tdata, m_tstrb, m_tuser, m_tlast, m_tvalid};
        end
    end

    // Drives one beat at the falling edge and holds it until accepted (bounded).
    task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic [127:0] u_drv,
                             input logic [127:0] u_exp, input logic l, input logic fwd, input logic e);
        logic rdy;
        int   tries;
        @(negedge clk);
        s_tdata  = d;
        s_tstrb  = s;
        s_tuser  = u_drv;
        s_tlast  = l;
        s_tvalid = 1'b1;
        #4;
        tries = 0;
        forever begin
            rdy = s_tready;
            if (m_tready) check("s_tready_when_m_ready", {255'd0, rdy}, 256'd1);
            @(posedge clk);
            if (rdy) break;
            tries++;
            if (tries > 200) begin
                check("accept_timeout", 256'd0, 256'd1);
                break;
            end
            #9;
        end
        if (rdy && fwd) exp_q.push_back('{d: d, s: s, u: u_exp, l: l, e: e});
    endtask

    task automatic send_pkt(input int n, input logic [7:0] dst, input logic [15:0] len,
                            input logic [7:0] last_strb, input logic fwd, input logic e);
        logic [127:0] tu;
        logic [63:0]  d;
        tu = {64'hC0DE_0000_0000_0000, 32'h0, dst, 8'h01, len};
        tu[127:96] = $urandom;
        for (int i = 0; i < n; i++) begin
            d = {$urandom, 32'(i)};
            send_beat(d, (i == n - 1) ? last_strb : 8'hFF, (i == 0) ? tu : ~tu, tu,
                      (i == n - 1), fwd, (i == n - 1) ? e : 1'b0);
        end
        if (fwd) exp_fwd++;
        else     exp_drop++;
        if (e)   exp_lerr++;
    endtask

    task automatic idle_in();
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        check(name, 256'(exp_q.size()), 256'd0);
    endtask

    task automatic check_stats(input string tag);
`ifdef NF10_TX_PORT_GATE_STATS_EN
        check({tag, "_fwd_pkt_cnt"},  256'(fwd_pkt_cnt),  256'(exp_fwd));
        check({tag, "_drop_pkt_cnt"}, 256'(drop_pkt_cnt), 256'(exp_drop));
        check({tag, "_len_err_cnt"},  256'(len_err_cnt),  256'(exp_lerr));
`else
        check({tag, "_no_len_err"}, {255'd0, len_err}, 256'd0);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] tu6;
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tstrb  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {54'd0, m_tdata, m_tstrb, m_tuser, m_tlast, m_tvalid}, 256'd0);
        check("reset_len_err", {255'd0, len_err}, 256'd0);
        check("reset_s_tready", {255'd0, s_tready}, 256'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 3-beat hit, len 20 = 8+8+4
        send_pkt(3, 8'h10, 16'd20, 8'h0F, 1'b1, 1'b0);
        // drop then immediate hit, no bubble
        send_pkt(2, MAC1, 16'd16, 8'hFF, 1'b0, 1'b0);
        send_pkt(2, MAC2, 16'd16, 8'hFF, 1'b1, 1'b0);
        // length error: tuser says 24, beats carry 20
        send_pkt(3, 8'h10, 16'd24, 8'h0F, 1'b1, 1'b1);
        idle_in();
        drain("drain_t1_3");

        // 5-cycle output stall mid-packet
        @(posedge clk); #2;
        fork
            send_pkt(6, 8'h10, 16'd48, 8'hFF, 1'b1, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #2 m_tready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("stall_s_tready_low", {255'd0, s_tready}, 256'd0);
                check("stall_m_tvalid_high", {255'd0, m_tvalid}, 256'd1);
                repeat (2) @(posedge clk);
                #2 m_tready = 1'b1;
            end
        join
        idle_in();
        drain("drain_t4");

        // single-beat packets alternating hit / dst 0
        for (int k = 0; k < 4; k++) begin
            send_pkt(1, 8'h10, 16'd8, 8'hFF, 1'b1, 1'b0);
            send_pkt(1, 8'h00, 16'd8, 8'hFF, 1'b0, 1'b0);
        end
        // multi-bit dst overlapping mask hits; all-but-mask misses
        send_pkt(2, 8'h30, 16'd12, 8'h0F, 1'b1, 1'b0);
        send_pkt(2, 8'hEF, 16'd16, 8'hFF, 1'b0, 1'b0);
        // byte count saturates: 8200*8 bytes clamps to 0xFFFF
        send_pkt(8200, 8'h10, 16'hFFFF, 8'hFF, 1'b1, 1'b0);
        idle_in();
        drain("drain_t5_sat");
        check_stats("pre_reset");

        // reset during beat 2 of a forwarded packet
        tu6 = {96'h0, 8'h10, 8'h01, 16'd16};
        send_beat(64'h1111_2222_3333_4444, 8'hFF, tu6, tu6, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        s_tdata = 64'h5555_6666_7777_8888;
        s_tuser = 128'h0;
        s_tlast = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_m_tvalid", {255'd0, m_tvalid}, 256'd0);
        check("async_reset_m_data", {192'd0, m_tdata}, 256'd0);
        check("async_reset_s_tready", {255'd0, s_tready}, 256'd1);
        s_tvalid = 1'b0;
        exp_fwd = 0; exp_drop = 0; exp_lerr = 0;
        check_stats("in_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_queue_empty", 256'(exp_q.size()), 256'd0);
        // remainder decoded as a fresh first beat: dst 0 -> dropped
        send_beat(64'h5555_6666_7777_8888, 8'hFF, 128'h0, 128'h0, 1'b1, 1'b0, 1'b0);
        exp_drop++;
        send_pkt(2, 8'h10, 16'd16, 8'hFF, 1'b1, 1'b0);
        idle_in();
        drain("drain_t6");
        check_stats("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
